gate2_tt_checker: RTL and testbench

- Self-checking truth-table sequencer for any 2-input gate in the library (OR, AND, XOR, ...).
- Acts as the driving and sampling end of the gate interface:
  - drives the gate's two inputs through all four vectors;
  - samples the gate output after a programmable settle time;
  - compares each sample against a 4-bit expected truth table.
- Reports pass/fail, mismatch count and first failing vector.
- Used in gate benches and on-board gate self-test.

---
 rtl/gate2_tt_checker.sv | 152 +++++++++++++++
 tb/tb_gate2_tt_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate2_tt_checker.sv
// Truth-table sequencer for a 2-input gate: sweeps {A,B} = 00..11, samples y_i after a settle delay.
// Optional macro GATE2_TT_HALT_ON_FAIL_EN: stop at the first mismatch and keep driving that vector.
module gate2_tt_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned SETTLE_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [3:0] expected_i,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [2:0] err_cnt_o,
  output logic [1:0] fail_idx_o,
  output logic       fail_valid_o
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

`ifdef GATE2_TT_HALT_ON_FAIL_EN
  localparam bit HaltOnFail = 1'b1;
`else
  localparam bit HaltOnFail = 1'b0;
`endif

  localparam bit ZeroSettle = (SETTLE_CYCLES == 0);
  localparam logic [SETTLE_W-1:0] CntLoad = ZeroSettle ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);
  // With no settle time the vector is sampled in the same cycle it is applied.
  localparam state_e StFirst = ZeroSettle ? StSample : StSettle;

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [3:0]          tbl_q, tbl_d;
  logic [1:0]          vec_q, vec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [2:0]          err_q, err_d;
  logic [1:0]          fidx_q, fidx_d;
  logic                fvalid_q, fvalid_d;
  logic                mismatch;

  assign mismatch = (y_i != tbl_q[idx_q]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tbl_d    = tbl_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fvalid_d = fvalid_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          tbl_d    = expected_i;
          idx_d    = 2'd0;
          cnt_d    = CntLoad;
          vec_d    = 2'd0;
          busy_d   = 1'b1;
          err_d    = 3'd0;
          fidx_d   = 2'd0;
          fvalid_d = 1'b0;
          pass_d   = 1'b0;
          state_d  = StFirst;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSample: begin
        if (mismatch) begin
          err_d = err_q + 3'd1;
          if (!fvalid_q) begin
            fidx_d   = idx_q;
            fvalid_d = 1'b1;
          end
        end
        if (idx_q == 2'd3 || (HaltOnFail && mismatch)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
          // A halted sweep leaves the failing vector on the gate for probing.
          vec_d   = (HaltOnFail && mismatch) ? idx_q : 2'd0;
        end else begin
          idx_d   = idx_q + 2'd1;
          vec_d   = idx_q + 2'd1;
          cnt_d   = CntLoad;
          state_d = StFirst;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      tbl_q    <= 4'd0;
      vec_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 3'd0;
      fidx_q   <= 2'd0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tbl_q    <= tbl_d;
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign a_o          = vec_q[1];
  assign b_o          = vec_q[0];
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_cnt_o    = err_q;
  assign fail_idx_o   = fidx_q;
  assign fail_valid_o = fvalid_q;

endmodule

// File: tb/tb_gate2_tt_checker.sv
// Bench for gate2_tt_checker: two instances (settle 1 and settle 0), each driving a table-defined
// gate, checked every cycle against a cycle-offset model plus directed literal expectations.
module tb_gate2_tt_checker;

`ifdef GATE2_TT_HALT_ON_FAIL_EN
  localparam bit Halt = 1'b1;
`else
  localparam bit Halt = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [3:0] expv [2];
  logic [3:0] gtt [2];
  logic [1:0] y_w, a_w, b_w, busy_w, done_w, pass_w, fv_w;
  logic [2:0] err_w [2];
  logic [1:0] fidx_w [2];

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  armed = 1'b0;

  always #5 clk = ~clk;

  // Gate under test: output is its own truth table indexed by {A,B}.
  assign y_w[0] = gtt[0][{a_w[0], b_w[0]}];
  assign y_w[1] = gtt[1][{a_w[1], b_w[1]}];

  gate2_tt_checker #(.SETTLE_CYCLES(1), .SETTLE_W(4)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .expected_i(expv[0]), .y_i(y_w[0]),
    .a_o(a_w[0]), .b_o(b_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]),
    .err_cnt_o(err_w[0]), .fail_idx_o(fidx_w[0]), .fail_valid_o(fv_w[0])
  );

  gate2_tt_checker #(.SETTLE_CYCLES(0), .SETTLE_W(4)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .expected_i(expv[1]), .y_i(y_w[1]),
    .a_o(a_w[1]), .b_o(b_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]),
    .err_cnt_o(err_w[1]), .fail_idx_o(fidx_w[1]), .fail_valid_o(fv_w[1])
  );

  // Model state: c counts cycles since the start was accepted (1 = first busy cycle).
  typedef struct {
    bit         act;
    int         c;
    logic [3:0] tbl;
    int         err;
    logic [1:0] fidx;
    bit         fv;
    bit         pass;
    bit         done;
    bit         holding;
    logic [1:0] hold;
  } mstate_t;

  mstate_t m [2];

  function automatic int per_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic rst, input int per,
                                   input logic st, input logic [3:0] e, input logic [3:0] g);
    mstate_t n;
    int      v;
    bit      mm;
    n = s;
    if (!rst) begin
      n = '{default: 0};
    end else if (s.done) begin
      n.done = 1'b0;
    end else if (s.act) begin
      if (s.c % per == 0) begin
        v  = (s.c - 1) / per;
        mm = (g[v] != s.tbl[v]);
        if (mm) begin
          n.err = s.err + 1;
          if (!s.fv) begin
            n.fv   = 1'b1;
            n.fidx = v[1:0];
          end
        end
        if (v == 3 || (Halt && mm)) begin
          n.act  = 1'b0;
          n.done = 1'b1;
          n.pass = (n.err == 0);
          if (Halt && mm) begin
            n.holding = 1'b1;
            n.hold    = v[1:0];
          end
        end
      end
      n.c = s.c + 1;
    end else if (st) begin
      n     = '{default: 0};
      n.act = 1'b1;
      n.c   = 1;
      n.tbl = e;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m[i] <= step(m[i], rst_n, per_of(i), start[i], expv[i], gtt[i]);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_inst(input int i);
    mstate_t    s;
    int         t;
    logic [1:0] ev;
    s = m[i];
    t = (s.c - 1) / per_of(i);
    if (s.act) ev = t[1:0];
    else if (s.holding) ev = s.hold;
    else ev = 2'd0;
    check($sformatf("m%0d_busy", i), 8'(busy_w[i]), 8'(s.act));
    check($sformatf("m%0d_vec", i), 8'({a_w[i], b_w[i]}), 8'(ev));
    check($sformatf("m%0d_done", i), 8'(done_w[i]), 8'(s.done));
    check($sformatf("m%0d_pass", i), 8'(pass_w[i]), 8'(s.pass));
    check($sformatf("m%0d_err", i), 8'(err_w[i]), 8'(s.err));
    check($sformatf("m%0d_fidx", i), 8'(fidx_w[i]), 8'(s.fidx));
    check($sformatf("m%0d_fvalid", i), 8'(fv_w[i]), 8'(s.fv));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) compare_inst(i);
    end
  end

  logic [1:0] rec_vec  [16];
  logic       rec_busy [16];
  logic       rec_done [16];
  logic       rec_pass [16];
  logic [2:0] rec_err  [16];
  logic [1:0] rec_fidx [16];
  logic       rec_fv   [16];

  // Start a sweep at edge t, then record cycles t+1..t+n. pmask[k] drives start for edge t+k+1;
  // rst_k asserts reset for edge t+rst_k+1.
  task automatic sweep(input int i, input logic [3:0] g, input logic [3:0] e, input int n,
                       input logic [15:0] pmask, input int rst_k);
    repeat (3) @(posedge clk);
    #1;
    gtt[i]   = g;
    expv[i]  = e;
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    expv[i]  = ~e;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rec_vec[k]  = {a_w[i], b_w[i]};
      rec_busy[k] = busy_w[i];
      rec_done[k] = done_w[i];
      rec_pass[k] = pass_w[i];
      rec_err[k]  = err_w[i];
      rec_fidx[k] = fidx_w[i];
      rec_fv[k]   = fv_w[i];
      start[i]    = pmask[k];
      rst_n       = (k == rst_k) ? 1'b0 : 1'b1;
    end
  endtask

  logic [15:0] seq1;
  logic [7:0]  seq0;
  int          ndone;

  initial begin
    rst_n   = 1'b0;
    start   = 2'b00;
    expv[0] = 4'd0;
    expv[1] = 4'd0;
    gtt[0]  = 4'd0;
    gtt[1]  = 4'd0;
    @(posedge clk);
    #1;
    armed = 1'b1;
    @(negedge clk);
    check("reset_busy", 8'(busy_w[0]), 8'd0);
    check("reset_err", 8'(err_w[0]), 8'd0);
    rst_n = 1'b1;

    // OR gate, matching table.
    sweep(0, 4'b1110, 4'b1110, 10, 16'h0000, 0);
    seq1 = 16'h05AF;
    for (int k = 1; k <= 8; k++) begin
      check("or_vec", 8'(rec_vec[k]), 8'(seq1[2*(8-k) +: 2]));
      check("or_busy", 8'(rec_busy[k]), 8'd1);
      check("or_nodone", 8'(rec_done[k]), 8'd0);
    end
    check("or_done9", 8'(rec_done[9]), 8'd1);
    check("or_busy9", 8'(rec_busy[9]), 8'd0);
    check("or_vec9", 8'(rec_vec[9]), 8'd0);
    check("or_pass", 8'(rec_pass[9]), 8'd1);
    check("or_err", 8'(rec_err[9]), 8'd0);
    check("or_fv", 8'(rec_fv[9]), 8'd0);
    check("or_done10", 8'(rec_done[10]), 8'd0);

    // AND gate against OR table: vectors 01 and 10 mismatch.
    sweep(0, 4'b1000, 4'b1110, 12, 16'h0000, 0);
    if (Halt) begin
      check("and_h_done5", 8'(rec_done[5]), 8'd1);
      check("and_h_err", 8'(rec_err[5]), 8'd1);
      check("and_h_vec5", 8'(rec_vec[5]), 8'd1);
      check("and_h_vec12", 8'(rec_vec[12]), 8'd1);
      check("and_h_pass", 8'(rec_pass[5]), 8'd0);
      check("and_h_fidx", 8'(rec_fidx[5]), 8'd1);
    end else begin
      check("and_done9", 8'(rec_done[9]), 8'd1);
      check("and_err", 8'(rec_err[9]), 8'd2);
      check("and_fidx", 8'(rec_fidx[9]), 8'd1);
      check("and_fv", 8'(rec_fv[9]), 8'd1);
      check("and_pass", 8'(rec_pass[9]), 8'd0);
      check("and_err_hold", 8'(rec_err[12]), 8'd2);
    end

    // Start pulses at t+3 and t+6 must not restart the sweep.
    sweep(0, 4'b1110, 4'b1110, 14, 16'h0024, 0);
    ndone = 0;
    for (int k = 1; k <= 14; k++) ndone += int'(rec_done[k]);
    check("busy_start_ndone", 8'(ndone), 8'd1);
    check("busy_start_done9", 8'(rec_done[9]), 8'd1);
    check("busy_start_busy8", 8'(rec_busy[8]), 8'd1);
    check("busy_start_busy10", 8'(rec_busy[10]), 8'd0);

    // Reset during vector 10.
    sweep(0, 4'b1000, 4'b1110, 8, 16'h0000, 5);
    check("rst_err5", 8'(rec_err[5]), 8'd1);
    check("rst_busy6", 8'(rec_busy[6]), 8'd0);
    check("rst_vec6", 8'(rec_vec[6]), 8'd0);
    check("rst_err6", 8'(rec_err[6]), 8'd0);
    check("rst_fv6", 8'(rec_fv[6]), 8'd0);
    sweep(0, 4'b1110, 4'b1110, 10, 16'h0000, 0);
    check("post_rst_done9", 8'(rec_done[9]), 8'd1);
    check("post_rst_pass", 8'(rec_pass[9]), 8'd1);

    // Zero settle, XOR gate.
    sweep(1, 4'b0110, 4'b0110, 6, 16'h0000, 0);
    seq0 = 8'b00011011;
    for (int k = 1; k <= 4; k++) begin
      check("xor_vec", 8'(rec_vec[k]), 8'(seq0[2*(4-k) +: 2]));
      check("xor_busy", 8'(rec_busy[k]), 8'd1);
    end
    check("xor_busy5", 8'(rec_busy[5]), 8'd0);
    check("xor_done5", 8'(rec_done[5]), 8'd1);
    check("xor_pass", 8'(rec_pass[5]), 8'd1);

    // Random traffic on both instances, checked by the model.
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) gtt[i] = 4'($urandom);
        expv[i]  = ($urandom_range(0, 1) == 0) ? gtt[i] : 4'($urandom);
        start[i] = ($urandom_range(0, 3) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
